// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that shares one N_REQ:1 data mux and
// drives a single registered output word with a valid/ready handshake.
// Optional feature: define ARB_BURST_HOLD_EN to let the granted requester
// keep the mux for up to MAX_BURST consecutive loads before priority rotates.
module rr_mux_arbiter #(
  parameter int N_REQ     = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_idx,
  output logic [N_REQ-1:0]           grant_onehot
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]   last_grant_p0;
  logic [W-1:0]       req_word [N_REQ];
  logic [2*N_REQ-1:0] valid_dbl;
  logic [2*N_REQ-1:0] valid_shift;
  logic [N_REQ-1:0]   valid_rot;
  logic [IDX_W:0]     shamt;
  logic [IDX_W:0]     sel_sum;
  logic [IDX_W-1:0]   first_k;
  logic [IDX_W-1:0]   sel;
  logic               any_req;
  logic               can_load;
  logic               load;

  // Split the packed requester bus into one word per requester for the mux.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_word[i] = req_data[i*W +: W];
    end
  end

  assign any_req  = |req_valid;
  assign can_load = !out_valid || out_ready;
  assign load     = rst && can_load && any_req;

`ifdef ARB_BURST_HOLD_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] burst_cnt_p0;
  logic             hold_ok;

  // The last winner keeps priority while it is still valid and its burst is short.
  assign hold_ok = (burst_cnt_p0 != '0) &&
                   (burst_cnt_p0 < CNT_W'(MAX_BURST)) &&
                   req_valid[last_grant_p0];
`endif

  // Rotate the valid vector so bit k is requester last_grant+1+k, then take
  // the lowest set bit and map it back to a requester index.
  always_comb begin
    shamt       = {1'b0, last_grant_p0} + (IDX_W+1)'(1);
    valid_dbl   = {req_valid, req_valid};
    valid_shift = valid_dbl >> shamt;
    valid_rot   = valid_shift[N_REQ-1:0];
    first_k     = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (valid_rot[k]) first_k = IDX_W'(k);
    end
    sel_sum = shamt + {1'b0, first_k};
    if (sel_sum >= (IDX_W+1)'(N_REQ)) sel_sum = sel_sum - (IDX_W+1)'(N_REQ);
    sel = sel_sum[IDX_W-1:0];
`ifdef ARB_BURST_HOLD_EN
    if (hold_ok) sel = last_grant_p0;
`endif
  end

  // Ready goes only to the selected requester, and only when a load happens.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (load && (sel == IDX_W'(i))) req_ready[i] = 1'b1;
    end
  end

  // One-hot view of the held word's owner, blank when nothing is held.
  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (out_valid && (grant_idx == IDX_W'(i))) grant_onehot[i] = 1'b1;
    end
  end

  // Output register: load the selected word, drain when empty-handed, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      grant_idx     <= '0;
      last_grant_p0 <= IDX_W'(N_REQ-1);
    end else if (can_load && any_req) begin
      out_valid     <= 1'b1;
      out_data      <= req_word[sel];
      grant_idx     <= sel;
      last_grant_p0 <= sel;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
    end
  end

`ifdef ARB_BURST_HOLD_EN
  // Count consecutive loads to the same requester; stalls leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      burst_cnt_p0 <= '0;
    end else if (load) begin
      if (hold_ok) burst_cnt_p0 <= burst_cnt_p0 + CNT_W'(1);
      else         burst_cnt_p0 <= CNT_W'(1);
    end
  end
`endif

endmodule
